// File: rtl/uart_alu_interface_if.sv
// Bus between the UART/ALU command sequencer and its surroundings (receiver, ALU, transmitter).
// master: the sequencer; slave: the environment that feeds it.
interface uart_alu_interface_if #(
  parameter int NDATA_BITS = 8,
  parameter int NOP_BITS   = 6
);
  logic [NDATA_BITS-1:0] i_rx_data;
  logic                  i_rx_done;
  logic [NDATA_BITS-1:0] i_alu_result;
  logic                  i_tx_done;
  logic [NDATA_BITS-1:0] o_alu_a;
  logic [NDATA_BITS-1:0] o_alu_b;
  logic [NOP_BITS-1:0]   o_alu_op;
  logic [NDATA_BITS-1:0] o_tx_data;
  logic                  o_tx_start;
  logic                  o_overrun;
  logic                  o_timeout;

  modport master (
    input  i_rx_data, i_rx_done, i_alu_result, i_tx_done,
    output o_alu_a, o_alu_b, o_alu_op, o_tx_data, o_tx_start, o_overrun, o_timeout
  );

  modport slave (
    output i_rx_data, i_rx_done, i_alu_result, i_tx_done,
    input  o_alu_a, o_alu_b, o_alu_op, o_tx_data, o_tx_start, o_overrun, o_timeout
  );
endinterface

// File: rtl/uart_alu_interface.sv
// Command sequencer: collects operand A, operand B, opcode from the UART receiver, runs the ALU,
// hands the result to the transmitter. Optional inter-byte timeout via `define UART_ALU_TIMEOUT_EN.
module uart_alu_interface #(
  parameter int NDATA_BITS     = 8,
  parameter int NOP_BITS       = 6,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  uart_alu_interface_if.master  bus
);

  typedef enum logic [2:0] {WAIT_A, WAIT_B, WAIT_OP, EXEC, WAIT_TX} state_e;

  state_e                state_q, state_d;
  logic                  rx_done_q, tx_done_q;
  logic                  rx_ev, tx_ev, timeout_hit;
  logic [NDATA_BITS-1:0] alu_a_q, alu_a_d;
  logic [NDATA_BITS-1:0] alu_b_q, alu_b_d;
  logic [NOP_BITS-1:0]   alu_op_q, alu_op_d;
  logic [NDATA_BITS-1:0] tx_data_q, tx_data_d;
  logic                  tx_start_q, tx_start_d;
  logic                  overrun_q, overrun_d;

  if (NOP_BITS > NDATA_BITS || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("uart_alu_interface: NOP_BITS must not exceed NDATA_BITS and TIMEOUT_CYCLES must be >= 1");
  end

  // Done inputs are levels that may stay high; only their rising edges count.
  assign rx_ev = bus.i_rx_done & ~rx_done_q;
  assign tx_ev = bus.i_tx_done & ~tx_done_q;

`ifdef UART_ALU_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          waiting;
  logic          timeout_q, timeout_d;

  assign waiting     = (state_q == WAIT_B) || (state_q == WAIT_OP);
  assign timeout_hit = waiting && !rx_ev && (cnt_q == CNT_LAST);

  // Counter is zero outside WAIT_B/WAIT_OP, so entering either state starts it from zero.
  always_comb begin
    cnt_d     = (waiting && !rx_ev && !timeout_hit) ? cnt_q + 1'b1 : '0;
    timeout_d = timeout_hit;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.o_timeout = timeout_q;
`else
  assign timeout_hit   = 1'b0;
  assign bus.o_timeout = 1'b0;
`endif

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) state_q <= WAIT_A;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_A:  if (rx_ev) state_d = WAIT_B;
      WAIT_B:  if (rx_ev) state_d = WAIT_OP; else if (timeout_hit) state_d = WAIT_A;
      WAIT_OP: if (rx_ev) state_d = EXEC;    else if (timeout_hit) state_d = WAIT_A;
      EXEC:    state_d = WAIT_TX;
      WAIT_TX: if (tx_ev) state_d = WAIT_A;
      default: state_d = WAIT_A;
    endcase
  end

  always_comb begin
    alu_a_d    = (state_q == WAIT_A  && rx_ev) ? bus.i_rx_data : alu_a_q;
    alu_b_d    = (state_q == WAIT_B  && rx_ev) ? bus.i_rx_data : alu_b_q;
    alu_op_d   = (state_q == WAIT_OP && rx_ev) ? bus.i_rx_data[NOP_BITS-1:0] : alu_op_q;
    // ALU has had a full cycle with stable operands by the time EXEC samples it.
    tx_data_d  = (state_q == EXEC) ? bus.i_alu_result : tx_data_q;
    tx_start_d = (state_q == EXEC);
    overrun_d  = overrun_q | (rx_ev && (state_q == EXEC || state_q == WAIT_TX));
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      rx_done_q  <= 1'b0;
      tx_done_q  <= 1'b0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      rx_done_q  <= bus.i_rx_done;
      tx_done_q  <= bus.i_tx_done;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      overrun_q  <= overrun_d;
    end
  end

  assign bus.o_alu_a    = alu_a_q;
  assign bus.o_alu_b    = alu_b_q;
  assign bus.o_alu_op   = alu_op_q;
  assign bus.o_tx_data  = tx_data_q;
  assign bus.o_tx_start = tx_start_q;
  assign bus.o_overrun  = overrun_q;

endmodule

// File: tb/tb_uart_alu_interface.sv
// Directed bench for uart_alu_interface: result scoreboard, level-held rx, overrun, async reset,
// inter-byte timeout (expectations follow whether UART_ALU_TIMEOUT_EN is defined).
module tb_uart_alu_interface;
  localparam int NDB = 8;
  localparam int NOPB = 6;
  localparam int TO = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_alu_interface_if #(.NDATA_BITS(NDB), .NOP_BITS(NOPB)) bus ();

  uart_alu_interface #(.NDATA_BITS(NDB), .NOP_BITS(NOPB), .TIMEOUT_CYCLES(TO)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  // ALU model: 0x20 add, 0x22 subtract, anything else xor.
  always_comb begin
    case (bus.o_alu_op)
      6'h20:   bus.i_alu_result = bus.o_alu_a + bus.o_alu_b;
      6'h22:   bus.i_alu_result = bus.o_alu_a - bus.o_alu_b;
      default: bus.i_alu_result = bus.o_alu_a ^ bus.o_alu_b;
    endcase
  end

  int n_checks = 0;
  int n_fail = 0;
  logic [NDB-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [NDB-1:0] b);
    bus.i_rx_data = b;
    bus.i_rx_done = 1'b1;
    tick();
    bus.i_rx_done = 1'b0;
    tick();
  endtask

  task automatic tx_pulse();
    bus.i_tx_done = 1'b0;
    tick();
    bus.i_tx_done = 1'b1;
    tick();
    bus.i_tx_done = 1'b0;
    tick();
  endtask

  task automatic run_cmd(input bit send_a, input logic [NDB-1:0] a, input logic [NDB-1:0] b,
                         input logic [NDB-1:0] op, input logic [NOPB-1:0] exp_op,
                         input logic [NDB-1:0] exp_res, input bit do_pulse);
    if (send_a) send_byte(a);
    send_byte(b);
    bus.i_rx_data = op;
    bus.i_rx_done = 1'b1;
    exp_q.push_back(exp_res);
    tick();
    chk("alu_a", bus.o_alu_a, a);
    chk("alu_b", bus.o_alu_b, b);
    chk("alu_op", bus.o_alu_op, exp_op);
    chk("tx_start_k", bus.o_tx_start, 1'b0);
    bus.i_rx_done = 1'b0;
    tick();
    chk("tx_start_k1", bus.o_tx_start, 1'b1);
    if (bus.o_tx_start === 1'b1 && exp_q.size() > 0)
      chk("tx_data", bus.o_tx_data, exp_q.pop_front());
    tick();
    chk("tx_start_k2", bus.o_tx_start, 1'b0);
    if (do_pulse) tx_pulse();
  endtask

  initial begin
    int pulses;
    int pulse_at;
    bus.i_rx_data = '0;
    bus.i_rx_done = 1'b0;
    bus.i_tx_done = 1'b0;
    repeat (3) tick();
    chk("rst_alu_a", bus.o_alu_a, 0);
    chk("rst_alu_b", bus.o_alu_b, 0);
    chk("rst_alu_op", bus.o_alu_op, 0);
    chk("rst_tx_data", bus.o_tx_data, 0);
    chk("rst_tx_start", bus.o_tx_start, 0);
    chk("rst_overrun", bus.o_overrun, 0);
    chk("rst_timeout", bus.o_timeout, 0);
    rst = 1'b0;

    // tx_done already high before WAIT_TX: must not complete the transmit.
    bus.i_tx_done = 1'b1;
    tick();
    run_cmd(1'b1, 8'h05, 8'h03, 8'h20, 6'h20, 8'h08, 1'b0);
    repeat (4) tick();
    chk("overrun_clear", bus.o_overrun, 0);
    send_byte(8'h11);
    chk("overrun_set", bus.o_overrun, 1);
    chk("ovr_alu_a", bus.o_alu_a, 8'h05);
    chk("ovr_alu_b", bus.o_alu_b, 8'h03);
    chk("ovr_alu_op", bus.o_alu_op, 6'h20);
    chk("ovr_tx_data", bus.o_tx_data, 8'h08);
    tx_pulse();
    run_cmd(1'b1, 8'h01, 8'h01, 8'h20, 6'h20, 8'h02, 1'b1);
    chk("overrun_sticky", bus.o_overrun, 1);

    // rx_done held high for 50 cycles yields a single byte event.
    bus.i_rx_data = 8'hAA;
    bus.i_rx_done = 1'b1;
    repeat (50) tick();
    bus.i_rx_done = 1'b0;
    tick();
    chk("hold_alu_a", bus.o_alu_a, 8'hAA);
    chk("hold_alu_b", bus.o_alu_b, 8'h01);
    run_cmd(1'b0, 8'hAA, 8'h10, 8'hE2, 6'h22, 8'h9A, 1'b1);

    // Asynchronous reset while in WAIT_OP, away from any clock edge.
    send_byte(8'h0F);
    send_byte(8'h0E);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_alu_a", bus.o_alu_a, 0);
    chk("arst_alu_b", bus.o_alu_b, 0);
    chk("arst_alu_op", bus.o_alu_op, 0);
    chk("arst_tx_data", bus.o_tx_data, 0);
    chk("arst_overrun", bus.o_overrun, 0);
    rst = 1'b0;
    tick();
    send_byte(8'h07);
    chk("post_rst_alu_a", bus.o_alu_a, 8'h07);
    chk("post_rst_alu_b", bus.o_alu_b, 0);
    run_cmd(1'b0, 8'h07, 8'h01, 8'h20, 6'h20, 8'h08, 1'b1);

    // Byte then silence.
    send_byte(8'h09);
    chk("to_alu_a", bus.o_alu_a, 8'h09);
    pulses = 0;
    pulse_at = -1;
    for (int i = 1; i <= 120; i++) begin
      tick();
      if (bus.o_timeout === 1'b1) begin
        pulses++;
        if (pulse_at < 0) pulse_at = i;
      end
    end
    send_byte(8'h04);
`ifdef UART_ALU_TIMEOUT_EN
    chk("to_pulses", pulses, 1);
    chk("to_pulse_cycle", pulse_at, 99);
    chk("to_next_alu_a", bus.o_alu_a, 8'h04);
`else
    chk("to_pulses", pulses, 0);
    chk("to_next_alu_b", bus.o_alu_b, 8'h04);
    chk("to_keep_alu_a", bus.o_alu_a, 8'h09);
`endif

    chk("sb_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
